// File: rtl/ap_engine_param.sv
// ap_engine_param: bit-serial associative processor over CELL_QUANT rows.
// Each row holds A, B (WORD_SIZE bits) and C (WORD_SIZE+1 bits, MSB = carry/borrow).
// Every op walks the bits LSB first. For each bit it runs a compare pass
// (tag the rows whose operand bits match a key) and then a write pass (store
// the result bit for that key into every tagged row).
// Optional feature: define AP_ROW_RANGE_EN to add row_lo/row_hi, which limit the rows an op touches.
module ap_engine_param #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned CELL_QUANT = 512,
    localparam int unsigned ADDR_W    = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            cmd,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  ap_state_irq,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [ADDR_W-1:0]     addr_in,
    input  logic [1:0]            sel_col,
    input  logic [WORD_SIZE:0]    data_in,
`ifdef AP_ROW_RANGE_EN
    input  logic [ADDR_W-1:0]     row_lo,
    input  logic [ADDR_W-1:0]     row_hi,
`endif
    output logic [WORD_SIZE:0]    data_out
);

    localparam int unsigned BIT_W  = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam int unsigned PASS_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_COMPARE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [WORD_SIZE-1:0] a_mem [CELL_QUANT];
    logic [WORD_SIZE-1:0] b_mem [CELL_QUANT];
    logic [WORD_SIZE:0]   c_mem [CELL_QUANT];
    logic                 tag_q [CELL_QUANT];
    logic                 cy_q  [CELL_QUANT];

    logic [BIT_W-1:0]  bit_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic [2:0]        op_q;
    logic              illegal_q;
    logic [ADDR_W-1:0] lo_q, hi_q;

    logic              is_arith;
    logic              last_pass;
    logic              last_bit;
    logic              res_bit;
    logic              cout_bit;
    logic              addr_ok;
    logic              host_wr;

    logic              busy_d, done_d, err_d, irq_d;

    assign is_arith  = (op_q == 3'd4) || (op_q == 3'd5);
    assign last_pass = (pass_cnt == (is_arith ? 3'd7 : 3'd3));
    assign last_bit  = (bit_cnt == BIT_W'(WORD_SIZE - 1));
    assign addr_ok   = ({1'b0, addr_in} < (ADDR_W + 1)'(CELL_QUANT));
    assign host_wr   = write_en && !busy && addr_ok;

    // State register
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = (cmd > 3'd5) ? ST_DONE : ST_INIT;
            ST_INIT:    state_nxt = ST_COMPARE;
            ST_COMPARE: state_nxt = ST_WRITE;
            ST_WRITE:   state_nxt = (last_pass && last_bit) ? ST_DONE : ST_COMPARE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output decode, registered below
    always_comb begin
        busy_d = (state_nxt != ST_IDLE);
        done_d = (state == ST_DONE);
        err_d  = (state == ST_DONE) && illegal_q;
        irq_d  = ap_state_irq;
        if (state == ST_IDLE && start) irq_d = 1'b0;
        if (state == ST_DONE)          irq_d = 1'b1;
    end

    // Registered handshake outputs
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            ap_state_irq <= 1'b0;
        end else begin
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
            ap_state_irq <= irq_d;
        end
    end

    // Operation capture and bit/pass counters
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            op_q      <= 3'd0;
            illegal_q <= 1'b0;
            bit_cnt   <= '0;
            pass_cnt  <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q      <= cmd;
                        illegal_q <= (cmd > 3'd5);
`ifdef AP_ROW_RANGE_EN
                        lo_q      <= row_lo;
                        hi_q      <= row_hi;
`else
                        lo_q      <= '0;
                        hi_q      <= ADDR_W'(CELL_QUANT - 1);
`endif
                    end
                end
                ST_INIT: begin
                    bit_cnt  <= '0;
                    pass_cnt <= '0;
                end
                ST_WRITE: begin
                    if (last_pass) begin
                        pass_cnt <= '0;
                        if (!last_bit) bit_cnt <= bit_cnt + BIT_W'(1);
                    end else begin
                        pass_cnt <= pass_cnt + PASS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result bit and new carry for the current key; every tagged row shares them
    always_comb begin
        res_bit  = 1'b0;
        cout_bit = 1'b0;
        case (op_q)
            3'd0: res_bit = pass_cnt[0] | pass_cnt[1];
            3'd1: res_bit = pass_cnt[0] ^ pass_cnt[1];
            3'd2: res_bit = pass_cnt[0] & pass_cnt[1];
            3'd3: res_bit = ~pass_cnt[0];
            3'd4: begin
                res_bit  = pass_cnt[0] ^ pass_cnt[1] ^ pass_cnt[2];
                cout_bit = (pass_cnt[0] & pass_cnt[1]) | (pass_cnt[0] & pass_cnt[2])
                         | (pass_cnt[1] & pass_cnt[2]);
            end
            3'd5: begin
                res_bit  = pass_cnt[0] ^ pass_cnt[1] ^ pass_cnt[2];
                cout_bit = (~pass_cnt[0] & pass_cnt[1]) | (~pass_cnt[0] & pass_cnt[2])
                         | (pass_cnt[1] & pass_cnt[2]);
            end
            default: ;
        endcase
    end

    // Cell array: host writes in IDLE, row-parallel compare/write passes during an op
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(CELL_QUANT); r++) begin
                a_mem[r] <= '0;
                b_mem[r] <= '0;
                c_mem[r] <= '0;
                tag_q[r] <= 1'b0;
                cy_q[r]  <= 1'b0;
            end
        end else begin
            if (host_wr) begin
                case (sel_col)
                    2'd0:    a_mem[addr_in] <= data_in[WORD_SIZE-1:0];
                    2'd1:    b_mem[addr_in] <= data_in[WORD_SIZE-1:0];
                    2'd2:    c_mem[addr_in] <= data_in;
                    default: ;
                endcase
            end
            for (int r = 0; r < int'(CELL_QUANT); r++) begin
                logic act;
                logic cy_eff;
                act    = (ADDR_W'(r) >= lo_q) && (ADDR_W'(r) <= hi_q);
                cy_eff = (pass_cnt == '0) ? c_mem[r][WORD_SIZE] : cy_q[r];
                case (state)
                    ST_INIT: begin
                        if (act) begin
                            if (is_arith) c_mem[r][WORD_SIZE] <= 1'b0;
                            else          c_mem[r]            <= '0;
                        end
                    end
                    ST_COMPARE: begin
                        if (pass_cnt == '0) cy_q[r] <= c_mem[r][WORD_SIZE];
                        if (is_arith)
                            tag_q[r] <= act && ({cy_eff, b_mem[r][bit_cnt], a_mem[r][bit_cnt]} == pass_cnt);
                        else
                            tag_q[r] <= act && ({b_mem[r][bit_cnt], a_mem[r][bit_cnt]} == pass_cnt[1:0]);
                    end
                    ST_WRITE: begin
                        if (tag_q[r]) begin
                            c_mem[r][bit_cnt] <= res_bit;
                            if (is_arith) c_mem[r][WORD_SIZE] <= cout_bit;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered host readback; the value reflects the array before any same-edge write
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (read_en) begin
            if (!addr_ok) begin
                data_out <= '0;
            end else begin
                case (sel_col)
                    2'd0:    data_out <= {1'b0, a_mem[addr_in]};
                    2'd1:    data_out <= {1'b0, b_mem[addr_in]};
                    2'd2:    data_out <= c_mem[addr_in];
                    default: data_out <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ap_engine_param.sv
// Directed bench for ap_engine_param: logic/arith results, latency, handshake, reset abort.
module tb_ap_engine_param;

    localparam int unsigned W  = 8;
    localparam int unsigned CQ = 512;
    localparam int unsigned AW = 9;

    logic          CLK100MHZ = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic          busy, done, err, ap_state_irq;
    logic          write_en = 1'b0;
    logic          read_en = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic [1:0]    sel_col = 2'd0;
    logic [W:0]    data_in = '0;
    logic [W:0]    data_out;
`ifdef AP_ROW_RANGE_EN
    logic [AW-1:0] row_lo = '0;
    logic [AW-1:0] row_hi = AW'(CQ - 1);
`endif

    int n_pass = 0;
    int n_total = 0;

    ap_engine_param #(.WORD_SIZE(W), .CELL_QUANT(CQ)) dut (
        .CLK100MHZ    (CLK100MHZ),
        .rst          (rst),
        .start        (start),
        .cmd          (cmd),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ap_state_irq (ap_state_irq),
        .write_en     (write_en),
        .read_en      (read_en),
        .addr_in      (addr_in),
        .sel_col      (sel_col),
        .data_in      (data_in),
`ifdef AP_ROW_RANGE_EN
        .row_lo       (row_lo),
        .row_hi       (row_hi),
`endif
        .data_out     (data_out)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic wr(input logic [1:0] col, input int addr, input logic [W:0] d);
        write_en = 1'b1; sel_col = col; addr_in = AW'(addr); data_in = d;
        @(posedge CLK100MHZ); #1;
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] col, input int addr, output logic [W:0] q);
        read_en = 1'b1; sel_col = col; addr_in = AW'(addr);
        @(posedge CLK100MHZ); #1;
        read_en = 1'b0;
        q = data_out;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] col, input int addr, input logic [W:0] exp);
        logic [W:0] q;
        rd(col, addr, q);
        check(tag, 32'(q), 32'(exp));
    endtask

    // Launch an op and count cycles to done; optionally poke start/write_en mid-op
    task automatic run_op(input string tag, input logic [2:0] op, input int exp_lat,
                          input logic exp_err, input bit inject);
        int   n;
        bit   got;
        logic e;
        logic irq;
        cmd = op; start = 1'b1;
        @(posedge CLK100MHZ); #1;
        start = 1'b0;
        n = 0; got = 1'b0; e = 1'b0; irq = 1'b0;
        while (!got && n < 400) begin
            if (inject && n == 10) begin start = 1'b1; cmd = 3'd7; end
            if (inject && n == 11) start = 1'b0;
            if (inject && n == 20) begin
                write_en = 1'b1; sel_col = 2'd0; addr_in = AW'(7); data_in = 9'h055;
            end
            if (inject && n == 21) write_en = 1'b0;
            @(posedge CLK100MHZ); #1;
            n++;
            if (done) begin got = 1'b1; e = err; irq = ap_state_irq; end
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        check({tag, "_irq"}, 32'(irq), 32'd1);
    endtask

    initial begin
        logic [W:0] q;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_irq", 32'(ap_state_irq), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        rst = 1'b0;
        @(posedge CLK100MHZ); #1;
        rd_chk("rst_c0", 2'd2, 0, 9'h000);

        // Logic ops on row 0
        wr(2'd0, 0, 9'h0C5);
        wr(2'd1, 0, 9'h03A);
        run_op("or", 3'd0, 66, 1'b0, 1'b0);
        rd_chk("or_c0", 2'd2, 0, 9'h0FF);
        run_op("xor", 3'd1, 66, 1'b0, 1'b0);
        rd_chk("xor_c0", 2'd2, 0, 9'h0FF);
        run_op("and", 3'd2, 66, 1'b0, 1'b0);
        rd_chk("and_c0", 2'd2, 0, 9'h000);
        run_op("not", 3'd3, 66, 1'b0, 1'b0);
        rd_chk("not_c0", 2'd2, 0, 9'h03A);

        // ADD with carry out and a plain sum
        wr(2'd0, 5, 9'h0FF); wr(2'd1, 5, 9'h001);
        wr(2'd0, 6, 9'h012); wr(2'd1, 6, 9'h034);
        run_op("add", 3'd4, 130, 1'b0, 1'b0);
        rd_chk("add_c5", 2'd2, 5, 9'h100);
        rd_chk("add_c6", 2'd2, 6, 9'h046);

        // SUB with and without borrow; operands must survive
        wr(2'd0, 7, 9'h010); wr(2'd1, 7, 9'h020);
        wr(2'd0, 8, 9'h020); wr(2'd1, 8, 9'h010);
        run_op("sub", 3'd5, 130, 1'b0, 1'b0);
        rd_chk("sub_c7", 2'd2, 7, 9'h1F0);
        rd_chk("sub_c8", 2'd2, 8, 9'h010);
        rd_chk("sub_a7", 2'd0, 7, 9'h010);
        rd_chk("sub_b7", 2'd1, 7, 9'h020);
        rd_chk("sub_a8", 2'd0, 8, 9'h020);
        rd_chk("sub_b8", 2'd1, 8, 9'h010);

        // Illegal command: immediate done+err, array untouched
        run_op("ill", 3'd7, 1, 1'b1, 1'b0);
        rd_chk("ill_c7", 2'd2, 7, 9'h1F0);

        // ADD with a stray start and host write while busy
        run_op("busy", 3'd4, 130, 1'b0, 1'b1);
        rd_chk("busy_a7", 2'd0, 7, 9'h010);
        rd_chk("busy_c7", 2'd2, 7, 9'h030);

        // Column 3 is a dead column
        wr(2'd3, 7, 9'h1AB);
        rd_chk("col3_rd", 2'd3, 7, 9'h000);

        // Same-cycle write and read returns the old value
        write_en = 1'b1; read_en = 1'b1; sel_col = 2'd0; addr_in = AW'(0); data_in = 9'h077;
        @(posedge CLK100MHZ); #1;
        write_en = 1'b0; read_en = 1'b0;
        check("rw_old", 32'(data_out), 32'h0C5);
        rd_chk("rw_new", 2'd0, 0, 9'h077);

        // Reset 40 cycles into an ADD
        cmd = 3'd4; start = 1'b1;
        @(posedge CLK100MHZ); #1;
        start = 1'b0;
        repeat (39) @(posedge CLK100MHZ);
        #1;
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge CLK100MHZ); #1;
        rst = 1'b0;
        repeat (2) @(posedge CLK100MHZ);
        #1;
        check("abort_nodone", 32'(done), 32'd0);
        rd_chk("abort_a5", 2'd0, 5, 9'h000);
        rd_chk("abort_c5", 2'd2, 5, 9'h000);
        wr(2'd0, 5, 9'h0FF); wr(2'd1, 5, 9'h001);
        run_op("post", 3'd4, 130, 1'b0, 1'b0);
        rd_chk("post_c5", 2'd2, 5, 9'h100);

`ifdef AP_ROW_RANGE_EN
        // AND limited to rows 2..3
        for (int r = 0; r < 6; r++) begin
            wr(2'd0, r, 9'h0FF); wr(2'd1, r, 9'h0FF); wr(2'd2, r, 9'h155);
        end
        row_lo = AW'(2); row_hi = AW'(3);
        run_op("range", 3'd2, 66, 1'b0, 1'b0);
        rd_chk("range_c1", 2'd2, 1, 9'h155);
        rd_chk("range_c2", 2'd2, 2, 9'h0FF);
        rd_chk("range_c3", 2'd2, 3, 9'h0FF);
        rd_chk("range_c4", 2'd2, 4, 9'h155);
        row_lo = '0; row_hi = AW'(CQ - 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
